// File: rtl/regfile_sb.sv
// Decode-stage register file: three zero-latency read ports with write-through
// bypass, two writeback ports (load port wins) and a pending-write scoreboard.
module regfile_sb #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 4,
   parameter int PC_IDX = 15
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [ADDR_W-1:0] ra1,
   input  logic [ADDR_W-1:0] ra2,
   input  logic [ADDR_W-1:0] ra3,
   input  logic [DATA_W-1:0] pc_in,
   output logic [DATA_W-1:0] rd1,
   output logic [DATA_W-1:0] rd2,
   output logic [DATA_W-1:0] rd3,
   input  logic              we_a,
   input  logic [ADDR_W-1:0] wa_a,
   input  logic [DATA_W-1:0] wd_a,
   input  logic              we_b,
   input  logic [ADDR_W-1:0] wa_b,
   input  logic [DATA_W-1:0] wd_b,
   input  logic              iss_valid,
   input  logic              iss_use1,
   input  logic              iss_use2,
   input  logic              iss_use3,
   input  logic              iss_wr,
   input  logic [ADDR_W-1:0] iss_dst,
   output logic              busy1,
   output logic              busy2,
   output logic              busy3,
   output logic              stall,
   output logic              wr_conflict,
   output logic [ADDR_W:0]   pend_count
);
   localparam int NREG = 1 << ADDR_W;
   localparam logic [ADDR_W-1:0] PC_A = ADDR_W'(PC_IDX);

   logic [DATA_W-1:0] regs_q [NREG];
   logic [NREG-1:0]   pend_q, pend_d;
   logic [ADDR_W:0]   count_q, count_d;
   logic              conflict_q, conflict_d;
   logic              issue_set;

   // Lookups 0..2 are the read ports; lookup 3 is the issuing destination (WAW).
   logic [ADDR_W-1:0] look_addr [4];
   logic [DATA_W-1:0] look_data [3];
   logic [3:0]        look_busy;

   assign look_addr[0] = ra1;
   assign look_addr[1] = ra2;
   assign look_addr[2] = ra3;
   assign look_addr[3] = iss_dst;

   generate
      for (genvar gi = 0; gi < 4; gi++) begin : g_look
         logic hit_a, hit_b, is_pc;
         assign hit_a = we_a && (wa_a == look_addr[gi]);
         assign hit_b = we_b && (wa_b == look_addr[gi]);
         assign is_pc = (look_addr[gi] == PC_A);
         assign look_busy[gi] = pend_q[look_addr[gi]] && !is_pc && !hit_a && !hit_b;
         if (gi < 3) begin : g_rd
            assign look_data[gi] = is_pc ? pc_in :
                                   hit_b ? wd_b  :
                                   hit_a ? wd_a  : regs_q[look_addr[gi]];
         end
      end
   endgenerate

   assign rd1   = look_data[0];
   assign rd2   = look_data[1];
   assign rd3   = look_data[2];
   assign busy1 = look_busy[0];
   assign busy2 = look_busy[1];
   assign busy3 = look_busy[2];

   assign stall = iss_valid && ((iss_use1 && look_busy[0]) ||
                                (iss_use2 && look_busy[1]) ||
                                (iss_use3 && look_busy[2]) ||
                                (iss_wr   && look_busy[3]));

   assign issue_set  = iss_valid && iss_wr && !stall && (iss_dst != PC_A);
   assign conflict_d = we_a && we_b && (wa_a == wa_b) && (wa_a != PC_A);

   // Clears are applied before sets so a same-edge set on the index wins.
   always_comb begin
      pend_d  = pend_q;
      count_d = '0;
      for (int i = 0; i < NREG; i++) begin
         if ((we_a && wa_a == ADDR_W'(i)) || (we_b && wa_b == ADDR_W'(i)))
            pend_d[i] = 1'b0;
         if (issue_set && iss_dst == ADDR_W'(i))
            pend_d[i] = 1'b1;
      end
      for (int i = 0; i < NREG; i++)
         count_d = count_d + {{ADDR_W{1'b0}}, pend_d[i]};
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         pend_q     <= '0;
         count_q    <= '0;
         conflict_q <= 1'b0;
      end else begin
         pend_q     <= pend_d;
         count_q    <= count_d;
         conflict_q <= conflict_d;
      end
   end

   // Port B is written last so it overrides port A on a same-index write.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < NREG; i++)
            regs_q[i] <= '0;
      end else begin
         if (we_a && wa_a != PC_A)
            regs_q[wa_a] <= wd_a;
         if (we_b && wa_b != PC_A)
            regs_q[wa_b] <= wd_b;
      end
   end

   assign wr_conflict = conflict_q;
   assign pend_count  = count_q;
endmodule

// File: tb/tb_regfile_sb.sv
// Randomised and directed bench for regfile_sb against a behavioural
// array/bit-vector model of the register file and scoreboard.
module tb_regfile_sb;
   logic        clk = 1'b0;
   logic        reset;
   logic [3:0]  ra1, ra2, ra3, wa_a, wa_b, iss_dst;
   logic [31:0] pc_in, wd_a, wd_b;
   logic [31:0] rd1, rd2, rd3;
   logic        we_a, we_b, iss_valid, iss_use1, iss_use2, iss_use3, iss_wr;
   logic        busy1, busy2, busy3, stall, wr_conflict;
   logic [4:0]  pend_count;

   regfile_sb #(.DATA_W(32), .ADDR_W(4), .PC_IDX(15)) dut (
      .clk(clk), .reset(reset), .ra1(ra1), .ra2(ra2), .ra3(ra3), .pc_in(pc_in),
      .rd1(rd1), .rd2(rd2), .rd3(rd3),
      .we_a(we_a), .wa_a(wa_a), .wd_a(wd_a), .we_b(we_b), .wa_b(wa_b), .wd_b(wd_b),
      .iss_valid(iss_valid), .iss_use1(iss_use1), .iss_use2(iss_use2), .iss_use3(iss_use3),
      .iss_wr(iss_wr), .iss_dst(iss_dst), .busy1(busy1), .busy2(busy2), .busy3(busy3),
      .stall(stall), .wr_conflict(wr_conflict), .pend_count(pend_count)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_pass   = 0;
   int cyc      = 0;

   logic [31:0] m_reg [16];
   bit   [15:0] m_pend;
   bit          m_conf;

   task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp)
         $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
      else
         n_pass++;
   endtask

   function automatic logic [31:0] exp_rd(input logic [3:0] a);
      if (a == 4'd15)                return pc_in;
      else if (we_b && wa_b == a)    return wd_b;
      else if (we_a && wa_a == a)    return wd_a;
      else                           return m_reg[a];
   endfunction

   function automatic bit exp_busy(input logic [3:0] a);
      return (a != 4'd15) && m_pend[a] && !(we_a && wa_a == a) && !(we_b && wa_b == a);
   endfunction

   function automatic bit exp_stall();
      return iss_valid && ((iss_use1 && exp_busy(ra1)) || (iss_use2 && exp_busy(ra2)) ||
                           (iss_use3 && exp_busy(ra3)) || (iss_wr && exp_busy(iss_dst)));
   endfunction

   task automatic idle();
      reset = 1'b0; ra1 = '0; ra2 = '0; ra3 = '0;
      we_a = 1'b0; wa_a = '0; wd_a = '0; we_b = 1'b0; wa_b = '0; wd_b = '0;
      iss_valid = 1'b0; iss_use1 = 1'b0; iss_use2 = 1'b0; iss_use3 = 1'b0;
      iss_wr = 1'b0; iss_dst = '0;
   endtask

   // Let inputs settle, compare every output against the model, log the cycle.
   task automatic settle_check();
      #1;
      check_val("rd1", rd1, exp_rd(ra1));
      check_val("rd2", rd2, exp_rd(ra2));
      check_val("rd3", rd3, exp_rd(ra3));
      check_val("busy1", busy1, exp_busy(ra1));
      check_val("busy2", busy2, exp_busy(ra2));
      check_val("busy3", busy3, exp_busy(ra3));
      check_val("stall", stall, exp_stall());
      check_val("wr_conflict", wr_conflict, m_conf);
      check_val("pend_count", pend_count, $countones(m_pend));
      $display("cyc %0d rst=%b ra=%0d/%0d/%0d rd=%h/%h/%h wa=%b:%0d wb=%b:%0d iss=%b dst=%0d stall=%b pend=%0d conf=%b",
               cyc, reset, ra1, ra2, ra3, rd1, rd2, rd3, we_a, wa_a, we_b, wa_b,
               iss_valid, iss_dst, stall, pend_count, wr_conflict);
   endtask

   // Advance one edge; the model applies the same edge semantics.
   task automatic tick();
      bit st;
      st = exp_stall();
      @(posedge clk);
      if (reset) begin
         for (int i = 0; i < 16; i++) m_reg[i] = '0;
         m_pend = '0;
         m_conf = 1'b0;
      end else begin
         m_conf = we_a && we_b && (wa_a == wa_b) && (wa_a != 4'd15);
         if (we_a && wa_a != 4'd15) m_reg[wa_a] = wd_a;
         if (we_b && wa_b != 4'd15) m_reg[wa_b] = wd_b;
         if (we_a) m_pend[wa_a] = 1'b0;
         if (we_b) m_pend[wa_b] = 1'b0;
         if (iss_valid && iss_wr && !st && iss_dst != 4'd15) m_pend[iss_dst] = 1'b1;
      end
      cyc++;
      @(negedge clk);
   endtask

   task automatic issue_dst(input logic [3:0] d);
      idle(); iss_valid = 1'b1; iss_wr = 1'b1; iss_dst = d;
      settle_check(); tick();
   endtask

   initial begin
      idle();
      pc_in = 32'h0000_1008;
      for (int i = 0; i < 16; i++) m_reg[i] = '0;
      m_pend = '0; m_conf = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      tick();
      idle();

      // Reset contents and PC read
      for (int i = 0; i < 16; i++) begin
         ra1 = 4'(i);
         settle_check();
         check_val("reset_read", rd1, (i == 15) ? 32'h0000_1008 : 32'h0);
         tick();
      end
      check_val("reset_pend", pend_count, 0);

      // Write-through bypass then storage
      idle(); we_a = 1'b1; wa_a = 4'd3; wd_a = 32'hDEAD_BEEF; ra2 = 4'd3;
      settle_check(); check_val("bypass_a", rd2, 32'hDEAD_BEEF); tick();
      idle(); ra2 = 4'd3;
      settle_check(); check_val("stored_a", rd2, 32'hDEAD_BEEF); tick();

      // Dual write to the same index
      idle(); we_a = 1'b1; wa_a = 4'd5; wd_a = 32'h11; we_b = 1'b1; wa_b = 4'd5; wd_b = 32'h22; ra1 = 4'd5;
      settle_check(); check_val("dual_bypass", rd1, 32'h22); tick();
      idle(); ra1 = 4'd5;
      settle_check(); check_val("dual_store", rd1, 32'h22); check_val("conflict_set", wr_conflict, 1'b1); tick();
      idle();
      settle_check(); check_val("conflict_clr", wr_conflict, 1'b0); tick();

      // RAW stall resolved by a same-cycle load writeback
      issue_dst(4'd7);
      idle(); settle_check(); check_val("raw_pend", pend_count, 1);
      iss_valid = 1'b1; iss_use1 = 1'b1; ra1 = 4'd7;
      settle_check(); check_val("raw_stall", stall, 1'b1);
      we_b = 1'b1; wa_b = 4'd7; wd_b = 32'h7777_0007;
      settle_check(); check_val("raw_release", stall, 1'b0); check_val("raw_fwd", rd1, 32'h7777_0007);
      tick();
      idle(); settle_check(); check_val("raw_cleared", pend_count, 0);

      // Set and clear on the same index in one edge
      issue_dst(4'd4);
      idle(); we_a = 1'b1; wa_a = 4'd4; wd_a = 32'h44;
      iss_valid = 1'b1; iss_wr = 1'b1; iss_dst = 4'd4;
      settle_check(); check_val("collide_nostall", stall, 1'b0); tick();
      idle(); ra1 = 4'd4;
      settle_check(); check_val("collide_pend", pend_count, 1); check_val("collide_busy", busy1, 1'b1);

      // Writes to the PC index are dropped
      idle(); pc_in = 32'h0000_2000; we_a = 1'b1; wa_a = 4'd15; wd_a = 32'hBAD0_BAD0;
      we_b = 1'b1; wa_b = 4'd15; wd_b = 32'hBAD1_BAD1; ra1 = 4'd15;
      settle_check(); check_val("pcw_read", rd1, 32'h0000_2000); tick();
      idle(); ra1 = 4'd15;
      settle_check(); check_val("pcw_after", rd1, 32'h0000_2000); check_val("pcw_noconf", wr_conflict, 1'b0);

      // Reset with three registers pending
      idle(); we_b = 1'b1; wa_b = 4'd4; wd_b = 32'h4;
      settle_check(); tick();
      issue_dst(4'd1); issue_dst(4'd2); issue_dst(4'd3);
      idle(); settle_check(); check_val("pre_reset_pend", pend_count, 3);
      reset = 1'b1; settle_check(); tick();
      idle(); ra1 = 4'd1; ra2 = 4'd2; ra3 = 4'd3;
      settle_check();
      check_val("post_reset_pend", pend_count, 0);
      check_val("post_reset_busy", {busy1, busy2, busy3}, 3'b000);
      tick();

      // Randomised traffic, addresses biased low to provoke hazards
      for (int n = 0; n < 1200; n++) begin
         reset     = ($urandom_range(0, 79) == 0);
         ra1       = ($urandom_range(0, 9) == 0) ? 4'd15 : 4'($urandom_range(0, 7));
         ra2       = 4'($urandom_range(0, 7));
         ra3       = 4'($urandom_range(0, 15));
         pc_in     = $urandom;
         we_a      = ($urandom_range(0, 2) == 0);
         wa_a      = ($urandom_range(0, 11) == 0) ? 4'd15 : 4'($urandom_range(0, 7));
         wd_a      = $urandom;
         we_b      = ($urandom_range(0, 3) == 0);
         wa_b      = 4'($urandom_range(0, 7));
         wd_b      = $urandom;
         iss_valid = ($urandom_range(0, 1) == 0);
         iss_use1  = 1'($urandom);
         iss_use2  = 1'($urandom);
         iss_use3  = 1'($urandom);
         iss_wr    = 1'($urandom);
         iss_dst   = ($urandom_range(0, 11) == 0) ? 4'd15 : 4'($urandom_range(0, 7));
         settle_check();
         tick();
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
